// File: rtl/eig_pkg.sv
// Types and helpers shared between the eigen-analysis core and coef_synth:
// regime one-hot codes, the coefficient FSM states and a signed saturator.
package eig_pkg;

    localparam logic [2:0] REG_UNDER = 3'b001;
    localparam logic [2:0] REG_CRIT  = 3'b010;
    localparam logic [2:0] REG_OVER  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQ_SIGMA,
        ST_SQ_KAPPA,
        ST_COMBINE,
        ST_EMIT
    } state_t;

    localparam int unsigned SAT_XW = 128;
    typedef logic signed [SAT_XW-1:0] sat_t;

    // Clamp x into the w-bit signed range; the result stays sign-extended.
    function automatic sat_t sat_w(input sat_t x, input int unsigned w);
        sat_t hi;
        sat_t lo;
        hi = (sat_t'(1) <<< (w - 1)) - sat_t'(1);
        lo = -hi - sat_t'(1);
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/coef_synth_if.sv
// Request/result bundle of coef_synth; the result side matches the
// eigen core's coefficient input (a0, a1, data_rdy).
interface coef_synth_if #(
    parameter int W = 32
) ();
    logic                ena;
    logic                start;
    logic signed [W-1:0] sigma;
    logic signed [W-1:0] kappa;
    logic [2:0]          regime;
    logic                busy;
    logic signed [W-1:0] a0;
    logic signed [W-1:0] a1;
    logic                data_rdy;
    logic                ovf;
    logic                err;

    modport master (
        output ena, start, sigma, kappa, regime,
        input  busy, a0, a1, data_rdy, ovf, err
    );

    modport slave (
        input  ena, start, sigma, kappa, regime,
        output busy, a0, a1, data_rdy, ovf, err
    );
endinterface

// File: rtl/coef_synth_seq_mul.sv
// Signed radix-2 shift-add multiplier; done pulses W+1 enabled cycles after
// start. The MSB partial product is subtracted (two's-complement weight).
module seq_mul #(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p,
    output logic                  done
);
    localparam int CW = $clog2(W + 1);
    typedef logic signed [2*W-1:0] prod_t;

    prod_t         r_acc;
    prod_t         r_mcand;
    logic [W-1:0]  r_mplier;
    logic [CW-1:0] r_cnt;
    logic          r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            if (start) begin
                r_acc    <= '0;
                r_mcand  <= prod_t'(a);
                r_mplier <= b;
                r_cnt    <= CW'(W);
            end else if (r_cnt != '0) begin
                if (r_mplier[0])
                    r_acc <= (r_cnt == CW'(1)) ? r_acc - r_mcand : r_acc + r_mcand;
                r_mcand  <= r_mcand <<< 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
                r_done   <= (r_cnt == CW'(1));
            end
        end
    end

    assign p    = r_acc;
    assign done = r_done;
endmodule

// File: rtl/coef_synth.sv
// Rebuilds x^2 + a1*x + a0 coefficients from (sigma, kappa, regime) using one
// shared sequential multiplier. Define COEF_SYNTH_ROUND_EN for round-half-up.
module coef_synth
    import eig_pkg::*;
#(
    parameter int W = 32,
    parameter int F = 16
) (
    input logic        clk,
    input logic        rst_n,
    coef_synth_if.slave cs
);
    typedef logic signed [2*W-1:0] prod_t;

`ifdef COEF_SYNTH_ROUND_EN
    localparam prod_t ROUND = prod_t'(1) <<< (F - 1);
`else
    localparam prod_t ROUND = '0;
`endif

    state_t              r_state, w_state_nx;
    logic                r_entry;
    logic                w_mul_start, w_mul_done, w_accept, w_reject, w_regime_ok;
    logic signed [W-1:0] r_sigma, r_kappa, w_mul_op;
    logic [2:0]          r_regime;
    prod_t               w_prod, w_sq_shift;
    logic signed [W-1:0] r_s2, r_k2, r_a0, r_a1, w_sq, w_a0, w_a1;
    logic                r_ovf_sq, r_ovf, r_err, w_sq_ovf, w_a0_ovf, w_a1_ovf;
    sat_t                w_sum, w_a1_full;

    assign w_regime_ok = cs.regime inside {REG_UNDER, REG_CRIT, REG_OVER};
    assign w_mul_op    = (r_state == ST_SQ_KAPPA) ? r_kappa : r_sigma;

    seq_mul #(.W(W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (cs.ena),
        .start (w_mul_start),
        .a     (w_mul_op),
        .b     (w_mul_op),
        .p     (w_prod),
        .done  (w_mul_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_entry <= 1'b0;
        end else if (cs.ena) begin
            r_state <= w_state_nx;
            r_entry <= (w_state_nx != r_state);
        end
    end

    // r_entry marks the first enabled cycle of a state, used to fire mul_start once.
    always_comb begin
        w_state_nx  = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_mul_start = 1'b0;
        if (cs.ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (cs.start) begin
                        if (w_regime_ok) begin
                            w_accept   = 1'b1;
                            w_state_nx = ST_SQ_SIGMA;
                        end else begin
                            w_reject = 1'b1;
                        end
                    end
                end
                ST_SQ_SIGMA: begin
                    w_mul_start = r_entry;
                    if (w_mul_done)
                        w_state_nx = (r_regime == REG_CRIT) ? ST_COMBINE : ST_SQ_KAPPA;
                end
                ST_SQ_KAPPA: begin
                    w_mul_start = r_entry;
                    if (w_mul_done)
                        w_state_nx = ST_COMBINE;
                end
                ST_COMBINE: w_state_nx = ST_EMIT;
                default:    w_state_nx = ST_IDLE;
            endcase
        end
        cs.busy     = (r_state != ST_IDLE);
        cs.data_rdy = (r_state == ST_EMIT) && cs.ena;
        cs.err      = r_err && cs.ena;
    end

    always_comb begin
        w_sq_shift = (w_prod + ROUND) >>> F;
        w_sq       = W'(sat_w(sat_t'(w_sq_shift), W));
        w_sq_ovf   = (sat_w(sat_t'(w_sq_shift), W) != sat_t'(w_sq_shift));

        w_sum = sat_t'(r_s2);
        if (r_regime == REG_UNDER)
            w_sum = sat_t'(r_s2) + sat_t'(r_k2);
        else if (r_regime == REG_OVER)
            w_sum = sat_t'(r_s2) - sat_t'(r_k2);
        w_a0     = W'(sat_w(w_sum, W));
        w_a0_ovf = (sat_w(w_sum, W) != w_sum);

        w_a1_full = -(sat_t'(r_sigma) <<< 1);
        w_a1      = W'(sat_w(w_a1_full, W));
        w_a1_ovf  = (sat_w(w_a1_full, W) != w_a1_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sigma  <= '0;
            r_kappa  <= '0;
            r_regime <= '0;
            r_s2     <= '0;
            r_k2     <= '0;
            r_ovf_sq <= 1'b0;
            r_a0     <= '0;
            r_a1     <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (cs.ena) begin
            r_err <= w_reject;
            if (w_accept) begin
                r_sigma  <= cs.sigma;
                r_kappa  <= cs.kappa;
                r_regime <= cs.regime;
                r_k2     <= '0;
                r_ovf_sq <= 1'b0;
            end
            if (w_mul_done && r_state == ST_SQ_SIGMA) begin
                r_s2     <= w_sq;
                r_ovf_sq <= r_ovf_sq | w_sq_ovf;
            end
            if (w_mul_done && r_state == ST_SQ_KAPPA) begin
                r_k2     <= w_sq;
                r_ovf_sq <= r_ovf_sq | w_sq_ovf;
            end
            if (r_state == ST_COMBINE) begin
                r_a0  <= w_a0;
                r_a1  <= w_a1;
                r_ovf <= r_ovf_sq | w_a0_ovf | w_a1_ovf;
            end
        end
    end

    assign cs.a0  = r_a0;
    assign cs.a1  = r_a1;
    assign cs.ovf = r_ovf;
endmodule

// File: tb/tb_coef_synth.sv
// Self-checking bench for coef_synth: vector table plus hand-written sequences
// for illegal regime, busy start, enable stall and mid-operation reset.
module tb_coef_synth;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_cnt = 0;

    coef_synth_if #(.W(32)) bus ();

    coef_synth #(.W(32), .F(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sigma;
        logic [31:0] kappa;
        logic [2:0]  regime;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        ovf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] a1;
        logic        ovf;
        int          lat;
        int          stamp;
    } exp_t;

    exp_t scb[$];
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.data_rdy) begin
            exp_t e;
            rdy_cnt++;
            if (scb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_data_rdy: got data_rdy=1 at cycle %0d expected none", cyc);
            end else begin
                e = scb.pop_front();
                check("a0", bus.a0, e.a0);
                check("a1", bus.a1, e.a1);
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
                check("latency", 32'(cyc - e.stamp + 1), 32'(e.lat));
            end
        end
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] k, input logic [2:0] r,
                            input bit push, input logic [31:0] ea0, input logic [31:0] ea1,
                            input logic eovf, input int elat);
        exp_t e;
        @(negedge clk);
        bus.sigma  = s;
        bus.kappa  = k;
        bus.regime = r;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.sigma  = $urandom;
        bus.kappa  = $urandom;
        bus.regime = 3'($urandom_range(0, 7));
        if (push) begin
            e.a0 = ea0; e.a1 = ea1; e.ovf = eovf; e.lat = elat; e.stamp = cyc;
            scb.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (scb.size() == 0) break;
        end
        check("scoreboard_drained", 32'(scb.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_a0"}, bus.a0, 32'd0);
        check({tag, "_a1"}, bus.a1, 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_data_rdy"}, 32'(bus.data_rdy), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc;
        tbl[0] = '{32'hFFFF0000, 32'h00008000, 3'b001, 32'h00014000, 32'h00020000, 1'b0, 70};
        tbl[1] = '{32'hFFFF0000, 32'h00008000, 3'b100, 32'h0000C000, 32'h00020000, 1'b0, 70};
        tbl[2] = '{32'h00020000, 32'h12345678, 3'b010, 32'h00040000, 32'hFFFC0000, 1'b0, 36};
        tbl[3] = '{32'h7FFF0000, 32'h00000000, 3'b001, 32'h7FFFFFFF, 32'h80000000, 1'b1, 70};
        tbl[4] = '{32'h00018000, 32'h00010000, 3'b100, 32'h00014000, 32'hFFFD0000, 1'b0, 70};
        tbl[5] = '{32'h00000000, 32'hFFFE0000, 3'b001, 32'h00040000, 32'h00000000, 1'b0, 70};
        tbl[6] = '{32'h00000000, 32'h7FFF0000, 3'b100, 32'h80000001, 32'h00000000, 1'b1, 70};
        tbl[7] = '{32'h80000000, 32'h00000000, 3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 36};

        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.start = 1'b0;
        bus.sigma = '0;
        bus.kappa = '0;
        bus.regime = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            do_start(tbl[i].sigma, tbl[i].kappa, tbl[i].regime, 1'b1,
                     tbl[i].a0, tbl[i].a1, tbl[i].ovf, tbl[i].lat);
            wait_done(200);
        end

        // Illegal regime: err in cycle 1 only, busy low, valid start in cycle 2.
        rc = rdy_cnt;
        do_start(32'h00010000, 32'h0, 3'b011, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        @(negedge clk);
        check("err_pulse", 32'(bus.err), 32'd1);
        check("err_busy", 32'(bus.busy), 32'd0);
        do_start(32'hFFFF0000, 32'h00008000, 3'b001, 1'b1, 32'h00014000, 32'h00020000, 1'b0, 70);
        check("err_cleared", 32'(bus.err), 32'd0);
        wait_done(200);
        check("err_one_rdy", 32'(rdy_cnt - rc), 32'd1);

        // Second start at cycle 10 is dropped.
        rc = rdy_cnt;
        do_start(32'h00020000, 32'h00008000, 3'b100, 1'b1, 32'h0003C000, 32'hFFFC0000, 1'b0, 70);
        repeat (9) @(posedge clk);
        check("busy_mid_op", 32'(bus.busy), 32'd1);
        do_start(32'h00010000, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        wait_done(200);
        repeat (60) @(posedge clk);
        check("busy_single_rdy", 32'(rdy_cnt - rc), 32'd1);

        // ena low for cycles 30..34 stretches latency to 75.
        do_start(32'hFFFF0000, 32'h00008000, 3'b001, 1'b1, 32'h00014000, 32'h00020000, 1'b0, 75);
        repeat (29) @(posedge clk);
        @(negedge clk);
        bus.ena = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_during_stall", 32'(bus.busy), 32'd1);
        bus.ena = 1'b1;
        wait_done(200);

        // Reset at cycle 20 aborts the operation.
        rc = rdy_cnt;
        do_start(32'h00018000, 32'h00010000, 3'b001, 1'b1, 32'h0, 32'h0, 1'b0, 70);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        scb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(posedge clk);
        check("midreset_no_rdy", 32'(rdy_cnt - rc), 32'd0);
        do_start(32'h00018000, 32'h00010000, 3'b001, 1'b1, 32'h00034000, 32'hFFFD0000, 1'b0, 70);
        wait_done(200);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/coef_synth.md
Name: coef_synth

Overview:
- Inverse of the eigen-analysis core: takes a pole description (real part sigma, spread kappa, one-hot regime) and rebuilds the characteristic-polynomial coefficients a0 (alpha) and a1 (beta) of x^2 + beta*x + alpha, in Q(W-F).F.
- Its output side drives the eigen core's input interface (a0, a1, data_rdy), so a regime/kappa target can be turned back into coefficients for watchdog self-test and round-trip checks.
- Uses one shared sequential multiplier instead of parallel DSP multipliers.

Parameters:
- W, 32, data width of all signed fixed-point values.
- F, 16, fractional bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; when low the FSM and multiplier hold state, and data_rdy/err are forced low
- start  input  1  request; sampled only in IDLE with ena high
- sigma  input  W  signed pole real part, Q(W-F).F
- kappa  input  W  signed root spread, Q(W-F).F; sign ignored because it is squared
- regime  input  3  one-hot: 001 underdamped, 010 critical, 100 overdamped
- busy  output  1  high from the cycle after start is accepted until data_rdy, inclusive
- a0  output  W  alpha result, held until the next result
- a1  output  W  beta result, held until the next result
- data_rdy  output  1  one-cycle pulse; a0/a1 are valid in that cycle
- ovf  output  1  saturation occurred in the last result; valid with data_rdy, held
- err  output  1  one-cycle pulse on an illegal regime

Behaviour:
- Reset: all outputs 0, FSM in IDLE, multiplier cleared. Reset mid-operation aborts the operation with no data_rdy.
- Inputs sigma, kappa and regime are latched at start acceptance. Later input changes are ignored.
- start while busy is ignored: no queueing, no error.
- Arithmetic rules:
  - a1 = -2*sigma, saturated to W bits.
  - s2 = (sigma*sigma) >>> F and k2 = (kappa*kappa) >>> F, each saturated to W bits.
  - a0 = s2 + k2 when underdamped, s2 - k2 when overdamped, s2 when critical. The add/subtract saturates to W signed bits.
  - ovf = OR of every saturation event in the operation.
- FSM states: IDLE, SQ_SIGMA, SQ_KAPPA, COMBINE, EMIT.
  - IDLE: on start, if regime is not exactly one-hot, pulse err next cycle and stay in IDLE (busy stays low). Otherwise latch inputs and go to SQ_SIGMA.
  - SQ_SIGMA: pulse mul_start in the entry cycle, then wait for mul_done. Go to SQ_KAPPA, or directly to COMBINE if critical.
  - SQ_KAPPA: same as SQ_SIGMA, multiplying kappa*kappa. Go to COMBINE.
  - COMBINE: compute a0 and a1, register them, go to EMIT.
  - EMIT: pulse data_rdy, go to IDLE. A new start is accepted in the following cycle.
- Multiplier latency: mul_done pulses W+1 cycles after mul_start.
- Total latency (ena held high, start sampled in cycle 0):
  - data_rdy in cycle 2W+6 (70 for W=32).
  - data_rdy in cycle W+4 when critical (36 for W=32).
- ena low stretches latency cycle-for-cycle. No state or value is lost.

Optional Feature:
- COEF_SYNTH_ROUND_EN defined: before each >>>F, add 2^(F-1) to the 2W-bit product, giving round-half-up. Latency is unchanged.
- Not defined: plain arithmetic-shift truncation toward minus infinity.

Decomposition:
- Shared package eig_pkg holds:
  - the regime one-hot localparams (REG_UNDER, REG_CRIT, REG_OVER), shared with the eigen core;
  - the FSM state enum;
  - the saturation helper function sat_w.
- Sub-module seq_mul: signed radix-2 shift-add multiplier.
  - Parameter W.
  - Ports: clk, rst_n, ena, start, a, b, p (2W bits), done.
  - Latency fixed at W+1 cycles from start to done.

Test Plan:
- Underdamped: sigma=0xFFFF0000 (-1.0), kappa=0x00008000 (0.5), regime=001 -> a0=0x00014000 (1.25), a1=0x00020000 (2.0), ovf=0, data_rdy exactly at cycle 70.
- Overdamped and critical:
  - Same sigma/kappa with regime=100 -> a0=0x0000C000 (0.75), a1=0x00020000.
  - sigma=0x00020000 (2.0), regime=010 -> a0=0x00040000, a1=0xFFFC0000, data_rdy at cycle 36.
- Saturation: sigma=0x7FFF0000, kappa=0, regime=001 -> a0=0x7FFFFFFF, a1=0x80000000, ovf=1.
- Illegal regime: regime=011 -> err pulse in cycle 1, no data_rdy, busy stays 0. A valid start in cycle 2 is then accepted normally.
- Busy and enable: second start at cycle 10 is ignored and only one data_rdy appears. ena held low for 5 cycles mid-operation moves data_rdy to cycle 75.
- Reset mid-operation: assert rst_n low at cycle 20 -> all outputs 0 immediately, no data_rdy. A subsequent start completes with correct values.
